// File: rtl/accel_serdes_pkg.sv
// Shared definitions for the accelerator serial link (serializer/deserializer).
//   deser_state_e  : 1-bit receive FSM state encoding (IDLE=0, RECV=1)
//   SERDES_WIDTH   : default link word width, shared by both link ends
//   SERDES_STAT_W  : width of the optional statistics counters
//   stat_next()    : saturating counter update with clear
package accel_serdes_pkg;

  localparam int SERDES_WIDTH  = 32;
  localparam int SERDES_STAT_W = 16;

  typedef enum logic {
    DESER_IDLE = 1'b0,
    DESER_RECV = 1'b1
  } deser_state_e;

  // A clear wins over the held value but not over a same-cycle increment,
  // so clear+increment leaves the counter at 1. Saturates at all-ones.
  function automatic logic [SERDES_STAT_W-1:0] stat_next(
    input logic [SERDES_STAT_W-1:0] cur,
    input logic                     inc,
    input logic                     clr
  );
    logic [SERDES_STAT_W-1:0] nxt;
    if (clr) begin
      nxt = inc ? SERDES_STAT_W'(1) : '0;
    end else if (inc && (cur != {SERDES_STAT_W{1'b1}})) begin
      nxt = cur + SERDES_STAT_W'(1);
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/deser_out_reg.sv
// Single-entry valid/ready holding register for reassembled words.
//   clk, rst   : clock and synchronous active-high reset
//   load_i     : a complete word is offered this cycle on data_i
//   data_i     : the completed word
//   ready_i    : downstream accepts data_o when valid_o & ready_i
//   data_o     : held word (keeps its value after being drained)
//   valid_o    : data_o holds an unconsumed word
//   accept_o   : offered word was written into the register
//   overrun_o  : offered word was dropped because the register was full
module deser_out_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             accept_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // A full register that is being drained this same cycle can take the new
  // word, so back-to-back words flow without a bubble.
  assign accept_o  = load_i & (~valid_q | ready_i);
  assign overrun_o = load_i & valid_q & ~ready_i;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (accept_o) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/deserializer.sv
// Receive side of the accelerator serial link. Rebuilds WIDTH-bit words from
// an LSB-first bit stream framed by frame_sync and presents them on a
// valid/ready interface; flags short frames and holding-register overruns.
//   clk, rst     : clock, synchronous active-high reset
//   serial_data  : serial bit, sampled when frame_sync=1
//   frame_sync   : high for every bit slot of a frame
//   out_data     : reassembled word, bit 0 = first bit received
//   out_valid    : out_data holds an unconsumed word
//   out_ready    : downstream accepts when out_valid & out_ready
//   busy         : a frame is partially received
//   err_short    : sticky, frame ended before WIDTH bits
//   err_overrun  : sticky, word completed while holding register full
//   err_clr      : pulse clearing the sticky flags (and stats counters)
// Optional macro DESER_STATS_EN adds frame_count (words delivered into the
// holding register) and drop_count (short frames plus overruns).
module deserializer
  import accel_serdes_pkg::*;
#(
  parameter int WIDTH = SERDES_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_data,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             err_short,
  output logic             err_overrun,
  input  logic             err_clr
`ifdef DESER_STATS_EN
  ,
  output logic [SERDES_STAT_W-1:0] frame_count,
  output logic [SERDES_STAT_W-1:0] drop_count
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  deser_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             err_short_q, err_short_d;
  logic             err_overrun_q, err_overrun_d;

  logic             word_done;
  logic             short_det;
  logic [WIDTH-1:0] word_full;
  logic             word_accept;
  logic             word_overrun;

  // The completing bit is folded in combinationally so the word can be
  // loaded on the same edge that samples its last bit.
  assign word_full = {serial_data, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    word_done = 1'b0;
    short_det = 1'b0;
    case (state_q)
      DESER_IDLE: begin
        if (frame_sync) begin
          shreg_d = word_full;
          cnt_d   = CNT_W'(1);
          state_d = DESER_RECV;
        end
      end
      DESER_RECV: begin
        if (frame_sync) begin
          shreg_d = word_full;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            word_done = 1'b1;
            cnt_d     = '0;
            state_d   = DESER_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // Partial word is simply abandoned; the shift register content is
          // overwritten by the next full frame.
          short_det = 1'b1;
          cnt_d     = '0;
          state_d   = DESER_IDLE;
        end
      end
      default: begin
        state_d = DESER_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A new error in the clear cycle keeps its flag set.
  always_comb begin
    err_short_d   = short_det    | (err_short_q   & ~err_clr);
    err_overrun_d = word_overrun | (err_overrun_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= DESER_IDLE;
      cnt_q         <= '0;
      shreg_q       <= '0;
      err_short_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      err_short_q   <= err_short_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  deser_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (word_done),
    .data_i   (word_full),
    .ready_i  (out_ready),
    .data_o   (out_data),
    .valid_o  (out_valid),
    .accept_o (word_accept),
    .overrun_o(word_overrun)
  );

  assign busy        = (state_q == DESER_RECV);
  assign err_short   = err_short_q;
  assign err_overrun = err_overrun_q;

`ifdef DESER_STATS_EN
  logic [SERDES_STAT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [SERDES_STAT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    frame_cnt_d = stat_next(frame_cnt_q, word_accept, err_clr);
    drop_cnt_d  = stat_next(drop_cnt_q, short_det | word_overrun, err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign frame_count = frame_cnt_q;
  assign drop_count  = drop_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = word_accept;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: directed scenarios with literal
// expectations, then randomized framing/backpressure checked every cycle
// against a bit-index based frame model.
module tb_deserializer;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         serial_data;
  logic         frame_sync;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         err_short;
  logic         err_overrun;
  logic         err_clr;
`ifdef DESER_STATS_EN
  logic [15:0]  frame_count;
  logic [15:0]  drop_count;
`endif

  deserializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_data(serial_data),
    .frame_sync (frame_sync),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .err_short  (err_short),
    .err_overrun(err_overrun),
    .err_clr    (err_clr)
`ifdef DESER_STATS_EN
    ,
    .frame_count(frame_count),
    .drop_count (drop_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Counts bits of the current frame and places each bit at its index.
  int           m_nbits = 0;
  logic [W-1:0] m_word  = '0;
  logic [W-1:0] m_data  = '0;
  bit           m_valid = 0;
  bit           m_short = 0;
  bit           m_over  = 0;
  int           m_fc    = 0;
  int           m_dc    = 0;

  task automatic model_step();
    bit done, sh, ov, acc;
    done = 0; sh = 0; ov = 0; acc = 0;
    if (rst) begin
      m_nbits = 0; m_word = '0; m_data = '0; m_valid = 0;
      m_short = 0; m_over = 0; m_fc = 0; m_dc = 0;
      return;
    end
    if (frame_sync) begin
      if (m_nbits == 0) m_word = '0;
      m_word[m_nbits] = serial_data;
      m_nbits++;
      if (m_nbits == W) begin
        done = 1;
        m_nbits = 0;
      end
    end else if (m_nbits != 0) begin
      sh = 1;
      m_nbits = 0;
    end
    if (done) begin
      if (!m_valid || out_ready) begin
        m_data = m_word; m_valid = 1; acc = 1;
      end else begin
        ov = 1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    if (err_clr) begin m_short = 0; m_over = 0; end
    if (sh) m_short = 1;
    if (ov) m_over = 1;
    if (err_clr) m_fc = acc;
    else if (acc && m_fc < 65535) m_fc++;
    if (err_clr) m_dc = (sh || ov) ? 1 : 0;
    else if ((sh || ov) && m_dc < 65535) m_dc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("out_data",    out_data,    m_data);
      cmp("out_valid",   {31'd0, out_valid},   {31'd0, m_valid});
      cmp("busy",        {31'd0, busy},        {31'd0, (m_nbits != 0)});
      cmp("err_short",   {31'd0, err_short},   {31'd0, m_short});
      cmp("err_overrun", {31'd0, err_overrun}, {31'd0, m_over});
`ifdef DESER_STATS_EN
      cmp("frame_count", {16'd0, frame_count}, 32'(m_fc));
      cmp("drop_count",  {16'd0, drop_count},  32'(m_dc));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_bits(input logic [W-1:0] w, input int from, input logic rdy);
    for (int i = from; i < W; i++) begin
      @(negedge clk);
      rst = 0; err_clr = 0;
      frame_sync = 1; serial_data = w[i]; out_ready = rdy;
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 0; err_clr = 0;
      frame_sync = 0; serial_data = 0; out_ready = rdy;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    frame_sync = 0; err_clr = 1;
    @(negedge clk);
    err_clr = 0;
  endtask

  logic [W-1:0] w44;

  initial begin
    rst = 1; serial_data = 0; frame_sync = 0; out_ready = 0; err_clr = 0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    cmp("rst_valid", {31'd0, out_valid}, 32'd0);
    cmp("rst_busy",  {31'd0, busy},      32'd0);
    cmp("rst_data",  out_data,           32'd0);
    cmp("rst_errs",  {30'd0, err_short, err_overrun}, 32'd0);
    rst = 0;

    // Single frame
    send_bits(32'hA5A51234, 0, 1);
    @(negedge clk); frame_sync = 0;
    cmp("single_valid", {31'd0, out_valid}, 32'd1);
    cmp("single_data",  out_data, 32'hA5A51234);
    cmp("single_busy",  {31'd0, busy}, 32'd0);
    @(negedge clk);
    cmp("single_pulse", {31'd0, out_valid}, 32'd0);
    cmp("single_noerr", {30'd0, err_short, err_overrun}, 32'd0);
    idle(2, 1);

    // Back-to-back frames
    send_bits(32'h00000001, 0, 1);
    @(negedge clk);
    cmp("b2b_first",  out_data, 32'h00000001);
    cmp("b2b_valid1", {31'd0, out_valid}, 32'd1);
    frame_sync = 1; serial_data = 0;
    send_bits(32'h80000000, 1, 1);
    @(negedge clk); frame_sync = 0;
    cmp("b2b_second", out_data, 32'h80000000);
    cmp("b2b_valid2", {31'd0, out_valid}, 32'd1);
    idle(2, 1);

    // Short frame then recovery
    send_bits(32'h12345678, W - 10, 1);
    @(negedge clk); frame_sync = 0;
    @(negedge clk);
    cmp("short_flag",  {31'd0, err_short}, 32'd1);
    cmp("short_valid", {31'd0, out_valid}, 32'd0);
    send_bits(32'hDEADBEEF, 0, 1);
    @(negedge clk); frame_sync = 0;
    cmp("short_next", out_data, 32'hDEADBEEF);
    cmp("short_sticky", {31'd0, err_short}, 32'd1);
    pulse_clr();
    cmp("short_clr", {31'd0, err_short}, 32'd0);

    // Backpressure / overrun
    send_bits(32'h11111111, 0, 0);
    send_bits(32'h22222222, 0, 0);
    @(negedge clk); frame_sync = 0; out_ready = 0;
    cmp("ovr_data",  out_data, 32'h11111111);
    cmp("ovr_flag",  {31'd0, err_overrun}, 32'd1);
    cmp("ovr_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk); out_ready = 1;
    @(negedge clk);
    cmp("ovr_drain_valid", {31'd0, out_valid}, 32'd0);
    cmp("ovr_drain_data",  out_data, 32'h11111111);
    pulse_clr();

    // Completion coincident with drain
    send_bits(32'h33333333, 0, 0);
    idle(3, 0);
    cmp("coin_hold", out_data, 32'h33333333);
    w44 = 32'h44444444;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      frame_sync = 1; serial_data = w44[i]; out_ready = (i == W - 1);
    end
    @(negedge clk); frame_sync = 0; out_ready = 0;
    cmp("coin_valid", {31'd0, out_valid}, 32'd1);
    cmp("coin_data",  out_data, 32'h44444444);
    cmp("coin_noovr", {31'd0, err_overrun}, 32'd0);
    idle(1, 1);

    // Reset mid-frame
    send_bits(32'hCAFEF00D, W - 16, 1);
    @(negedge clk); frame_sync = 0; rst = 1;
    @(negedge clk); rst = 0;
    cmp("mrst_valid", {31'd0, out_valid}, 32'd0);
    cmp("mrst_busy",  {31'd0, busy}, 32'd0);
    cmp("mrst_data",  out_data, 32'd0);
    send_bits(32'h0F0F0F0F, 0, 1);
    @(negedge clk); frame_sync = 0;
    cmp("mrst_next", out_data, 32'h0F0F0F0F);
`ifdef DESER_STATS_EN
    cmp("mrst_fcount", {16'd0, frame_count}, 32'd1);
`endif
    idle(2, 1);

    // Randomized framing, backpressure, clears and rare resets
    for (int it = 0; it < 90; it++) begin
      int len;
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(1, W - 1) : W * $urandom_range(1, 3);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        frame_sync  = 1;
        serial_data = $urandom_range(0, 1);
        out_ready   = ($urandom_range(0, 3) != 0);
        err_clr     = ($urandom_range(0, 49) == 0);
        rst         = ($urandom_range(0, 799) == 0);
      end
      for (int g = 0, n = $urandom_range(0, 3); g < n; g++) begin
        @(negedge clk);
        frame_sync = 0; serial_data = 0; rst = 0;
        out_ready  = ($urandom_range(0, 1) != 0);
        err_clr    = ($urandom_range(0, 19) == 0);
      end
    end
    idle(4, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
